// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice reused LSB-first over WIDTH cycles, carry held in a register.
// Result lands WIDTH cycles after start is accepted; start is only honoured in IDLE or DONE, never queued.

module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q, sb_q;
  logic             c_q;
  // Only the upper WIDTH-1 bits of the result shifter are ever read back, so bit 0 is not stored.
  logic [WIDTH-2:0] r_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             s, co;
  logic [WIDTH-1:0] sum_d;
  logic             last;

  fulladder u_fa (
    .a_i  (sa_q[0]),
    .b_i  (sb_q[0]),
    .c_i  (c_q),
    .s_o  (s),
    .co_o (co)
  );

  assign sum_d = {s, r_q};
  assign last  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      c_q     <= 1'b0;
      r_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            c_q     <= cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          r_q   <= sum_d[WIDTH-1:1];
          c_q   <= co;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            sum_q   <= sum_d;
            cout_q  <= co;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=8 and WIDTH=3.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       cout8, busy8, done8;

  logic       start3 = 1'b0, cin3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0, sum3;
  logic       cout3, busy3, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .sum(sum3), .cout(cout3), .busy(busy3), .done(done3)
  );

  // One WIDTH=8 add: checks busy length, result, and that done is a single pulse.
  task automatic add8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [7:0] es, input logic ec, input string nm);
    int busy_n;
    bit seen;
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_n = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        seen = 1;
        break;
      end
      if (busy8) busy_n++;
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s done_timeout: no done within 20 cycles", nm);
    end
    checks++;
    if (busy_n !== 8) begin
      errors++; $display("FAIL %s busy_len: got %0d cycles, want 8", nm, busy_n);
    end
    checks++;
    if (sum8 !== es || cout8 !== ec || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s result: got sum=%h cout=%b busy=%b, want sum=%h cout=%b busy=0",
               nm, sum8, cout8, busy8, es, ec);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0) begin
      errors++; $display("FAIL %s done_pulse: got done=%b after one cycle, want 0", nm, done8);
    end
  endtask

  task automatic add3(input logic [2:0] av, input logic [2:0] bv, input logic cv,
                      input logic [2:0] es, input logic ec, input string nm);
    int busy_n;
    bit seen;
    @(negedge clk);
    a3 = av; b3 = bv; cin3 = cv; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    busy_n = 0; seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done3) begin
        seen = 1;
        break;
      end
      if (busy3) busy_n++;
      @(negedge clk);
    end
    checks++;
    if (!seen || busy_n !== 3) begin
      errors++; $display("FAIL %s timing: done_seen=%0d busy=%0d cycles, want 1 and 3", nm, seen, busy_n);
    end
    checks++;
    if (sum3 !== es || cout3 !== ec) begin
      errors++;
      $display("FAIL %s result: a=%h b=%h cin=%b got sum=%h cout=%b, want sum=%h cout=%b",
               nm, av, bv, cv, sum3, cout3, es, ec);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_w8: got sum=%h cout=%b busy=%b done=%b, want all 0", sum8, cout8, busy8, done8);
    end
    checks++;
    if (sum3 !== 3'h0 || cout3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_w3: got sum=%h cout=%b busy=%b done=%b, want all 0", sum3, cout3, busy3, done3);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_nominal;
    add8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "nominal");
  endtask

  task automatic test_carry;
    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "carry_wrap");
    add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "carry_in");
  endtask

  task automatic test_start_ignored;
    int busy_n, done_n;
    logic [7:0] s_seen;
    logic c_seen;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_n = 0; done_n = 0; s_seen = 8'hxx; c_seen = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      if (busy8) busy_n++;
      if (done8) begin
        done_n++; s_seen = sum8; c_seen = cout8;
      end
      if (i == 3) begin
        a8 = 8'h70; b8 = 8'h70; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (done_n !== 1 || busy_n !== 8) begin
      errors++; $display("FAIL ignore_timing: got %0d done, %0d busy, want 1 and 8", done_n, busy_n);
    end
    checks++;
    if (s_seen !== 8'h03 || c_seen !== 1'b0) begin
      errors++; $display("FAIL ignore_result: got sum=%h cout=%b, want sum=03 cout=0", s_seen, c_seen);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
    end
    @(negedge clk);
    rst = 1'b0;
    add8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back;
    int done_n, last_cyc;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    done_n = 0; last_cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done8) begin
        done_n++;
        checks++;
        if (i - last_cyc !== 9) begin
          errors++; $display("FAIL b2b_gap: done %0d at cycle %0d, %0d after previous, want 9", done_n, i, i - last_cyc);
        end
        checks++;
        if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
          errors++; $display("FAIL b2b_result: got sum=%h cout=%b, want sum=00 cout=1", sum8, cout8);
        end
        last_cyc = i;
      end
    end
    start8 = 1'b0;
    checks++;
    if (done_n !== 4) begin
      errors++; $display("FAIL b2b_count: got %0d done pulses in 40 cycles, want 4", done_n);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy=%b done=%b after start dropped, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_random;
    logic [7:0] av, bv;
    logic [2:0] a3v, b3v;
    logic       cv;
    logic [8:0] e8;
    logic [3:0] e3;
    for (int i = 0; i < 16; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      cv = 1'($urandom_range(0, 1));
      e8 = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
      add8(av, bv, cv, e8[7:0], e8[8], "rand_w8");
    end
    for (int i = 0; i < 16; i++) begin
      a3v = 3'($urandom_range(0, 7));
      b3v = 3'($urandom_range(0, 7));
      cv  = 1'($urandom_range(0, 1));
      e3  = {1'b0, a3v} + {1'b0, b3v} + {3'd0, cv};
      add3(a3v, b3v, cv, e3[2:0], e3[3], "rand_w3");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_carry();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
